// File: rtl/ram_arbiter.sv
// Round-robin arbiter granting MASTER_COUNT masters access to a single-port byte-lane RAM.
// Optional feature: define RAM_ARBITER_RANGE_CHECK_EN to add the per-master address range error output.
module ram_arbiter #(
    parameter int unsigned MASTER_COUNT = 2,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH_LOG2   = 10,
    parameter int unsigned WAIT_STATES  = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [MASTER_COUNT-1:0]              request,
    input  logic [MASTER_COUNT-1:0]              write_enable,
    input  logic [MASTER_COUNT*32-1:0]           address,
    input  logic [MASTER_COUNT*DATA_WIDTH/8-1:0] write_select,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0]   write_data,
    output logic [MASTER_COUNT-1:0]              grant,
    output logic [MASTER_COUNT-1:0]              ack,
    output logic [DATA_WIDTH-1:0]                read_data
`ifdef RAM_ARBITER_RANGE_CHECK_EN
    ,
    output logic [MASTER_COUNT-1:0]              error
`endif
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned IDX_W     = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int unsigned WORDS     = 1 << DEPTH_LOG2;
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(MASTER_COUNT - 1);
    localparam logic [3:0]       WAIT_LAST = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESPOND
    } state_t;

    state_t                    state_q;
    logic [3:0]                wait_q;
    logic [IDX_W-1:0]          last_q;
    logic [IDX_W-1:0]          owner_q;
    logic [MASTER_COUNT-1:0]   grant_q;
    logic [MASTER_COUNT-1:0]   ack_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      cmd_we_q;
    logic [31:0]               cmd_addr_q;
    logic [BYTES-1:0]          cmd_sel_q;
    logic [DATA_WIDTH-1:0]     cmd_wdata_q;
    logic [MASTER_COUNT-1:0]   err_q;

    logic [DATA_WIDTH-1:0]     mem_q [WORDS];

    logic                      win_found_c;
    logic [IDX_W-1:0]          win_idx_c;
    logic [IDX_W-1:0]          cand_c;
    logic [MASTER_COUNT-1:0]   win_oh_c;
    logic                      win_we_c;
    logic [31:0]               win_addr_c;
    logic [BYTES-1:0]          win_sel_c;
    logic [DATA_WIDTH-1:0]     win_wdata_c;
    logic [DEPTH_LOG2-1:0]     word_idx_c;
    logic                      access_done_c;
    logic                      range_err_c;
    logic                      mem_we_c;
    logic [DATA_WIDTH-1:0]     rd_value_c;

    // Round-robin search starting just after the last-served master, plus command mux.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int unsigned k = 1; k <= MASTER_COUNT; k++) begin
            cand_c = IDX_W'((32'(last_q) + k) % MASTER_COUNT);
            if (!win_found_c && request[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
        win_oh_c    = MASTER_COUNT'(1) << win_idx_c;
        win_we_c    = 1'b0;
        win_addr_c  = '0;
        win_sel_c   = '0;
        win_wdata_c = '0;
        for (int unsigned i = 0; i < MASTER_COUNT; i++) begin
            if (win_idx_c == IDX_W'(i)) begin
                win_we_c    = write_enable[i];
                win_addr_c  = address[32*i +: 32];
                win_sel_c   = write_select[BYTES*i +: BYTES];
                win_wdata_c = write_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    assign word_idx_c    = cmd_addr_q[DEPTH_LOG2+1:2];
    assign access_done_c = (state_q == S_ACCESS) && (wait_q == WAIT_LAST);

`ifdef RAM_ARBITER_RANGE_CHECK_EN
    logic unused_addr_c;
    assign range_err_c   = (cmd_addr_q >> (DEPTH_LOG2 + 2)) != 32'd0;
    assign unused_addr_c = ^cmd_addr_q[1:0];
`else
    // Upper address bits are ignored, so out-of-range addresses alias into memory.
    logic unused_addr_c;
    assign range_err_c   = 1'b0;
    assign unused_addr_c = ^{cmd_addr_q[31:DEPTH_LOG2+2], cmd_addr_q[1:0]};
`endif

    assign mem_we_c   = access_done_c && cmd_we_q && !range_err_c;
    assign rd_value_c = (cmd_we_q || range_err_c) ? '0 : mem_q[word_idx_c];

    // Memory array is never reset; async reset forces IDLE, so an interrupted write never lands.
    always_ff @(posedge clock) begin
        if (mem_we_c) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (cmd_sel_q[b]) begin
                    mem_q[word_idx_c][8*b +: 8] <= cmd_wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            last_q      <= LAST_RST;
            owner_q     <= '0;
            grant_q     <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_sel_q   <= '0;
            cmd_wdata_q <= '0;
            err_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_found_c) begin
                        cmd_we_q    <= win_we_c;
                        cmd_addr_q  <= win_addr_c;
                        cmd_sel_q   <= win_sel_c;
                        cmd_wdata_q <= win_wdata_c;
                        owner_q     <= win_idx_c;
                        grant_q     <= win_oh_c;
                        wait_q      <= '0;
                        state_q     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (wait_q == WAIT_LAST) begin
                        ack_q   <= grant_q;
                        rdata_q <= rd_value_c;
                        err_q   <= range_err_c ? grant_q : '0;
                        state_q <= S_RESPOND;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                S_RESPOND: begin
                    ack_q   <= '0;
                    grant_q <= '0;
                    rdata_q <= '0;
                    err_q   <= '0;
                    last_q  <= owner_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant     = grant_q;
    assign ack       = ack_q;
    assign read_data = rdata_q;

`ifdef RAM_ARBITER_RANGE_CHECK_EN
    assign error = err_q;
`else
    logic unused_err_c;
    assign unused_err_c = ^err_q;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter at default parameters (2 masters, 32-bit, 1 wait state).
module tb_ram_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  request;
    logic [1:0]  write_enable;
    logic [63:0] address;
    logic [7:0]  write_select;
    logic [63:0] write_data;
    logic [1:0]  grant;
    logic [1:0]  ack;
    logic [31:0] read_data;
`ifdef RAM_ARBITER_RANGE_CHECK_EN
    logic [1:0]  error;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    ram_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .request      (request),
        .write_enable (write_enable),
        .address      (address),
        .write_select (write_select),
        .write_data   (write_data),
        .grant        (grant),
        .ack          (ack),
        .read_data    (read_data)
`ifdef RAM_ARBITER_RANGE_CHECK_EN
        ,
        .error        (error)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One full transaction; request sampled at edge t, ack expected in cycle t+3.
    task automatic txn(input string tag, input int m, input logic we, input logic [31:0] a,
                       input logic [3:0] sel, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err);
        logic [1:0] oh;
        oh = 2'b01 << m;
        @(negedge clock);
        request = '0;
        request[m] = 1'b1;
        write_enable[m] = we;
        address[32*m +: 32] = a;
        write_select[4*m +: 4] = sel;
        write_data[32*m +: 32] = wd;
        @(negedge clock);
        request = '0;
        chk({tag, "_grant"}, 64'(grant), 64'(oh));
        chk({tag, "_ack_a1"}, 64'(ack), 64'd0);
        chk({tag, "_rd_a1"}, 64'(read_data), 64'd0);
        @(negedge clock);
        chk({tag, "_ack_a2"}, 64'(ack), 64'd0);
        @(negedge clock);
        chk({tag, "_ack"}, 64'(ack), 64'(oh));
        chk({tag, "_rdata"}, 64'(read_data), we ? 64'd0 : 64'(exp_rd));
`ifdef RAM_ARBITER_RANGE_CHECK_EN
        chk({tag, "_err"}, 64'(error), exp_err ? 64'(oh) : 64'd0);
`else
        if (exp_err) $display("note: %s range error not built in", tag);
`endif
        @(negedge clock);
        chk({tag, "_ack_off"}, 64'(ack), 64'd0);
        chk({tag, "_grant_off"}, 64'(grant), 64'd0);
        chk({tag, "_rd_off"}, 64'(read_data), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [1:0] seen;
        int         waited;
        reset        = 1'b0;
        request      = '0;
        write_enable = '0;
        address      = '0;
        write_select = '0;
        write_data   = '0;
        #3;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdata", 64'(read_data), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Basic write/read, byte lanes, ignored low address bits, zero select.
        txn("wr10", 0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        txn("rd10", 0, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        txn("wrAA", 0, 1'b1, 32'h10, 4'h1, 32'h000000AA, 32'h0, 1'b0);
        txn("rd13", 0, 1'b0, 32'h13, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0);
        txn("wrsel0", 1, 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 32'h0, 1'b0);
        txn("rdm1", 1, 1'b0, 32'h10, 4'h0, 32'h0, 32'hDEADBEAA, 1'b0);
        txn("wr20", 1, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("wr00", 0, 1'b1, 32'h00, 4'hF, 32'h0BADF00D, 32'h0, 1'b0);

        // Reset in the second ACCESS cycle of a write abandons it.
        @(negedge clock);
        request = 2'b01;
        write_enable[0] = 1'b1;
        address[31:0] = 32'h20;
        write_select[3:0] = 4'hF;
        write_data[31:0] = 32'h12345678;
        @(negedge clock);
        request = '0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrst_grant", 64'(grant), 64'd0);
        chk("midrst_ack", 64'(ack), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        seen = '0;
        repeat (4) begin
            @(negedge clock);
            seen = seen | ack;
        end
        chk("midrst_no_ack", 64'(seen), 64'd0);
        txn("rd20", 0, 1'b0, 32'h20, 4'h0, 32'h0, 32'hCAFEF00D, 1'b0);

        // Continuous requests from reset alternate 0,1,0,1; memory survives reset.
        do_reset();
        request = 2'b11;
        write_enable = 2'b00;
        address = {32'h20, 32'h10};
        for (int n = 0; n < 4; n++) begin
            waited = 0;
            @(negedge clock);
            while (ack == 2'b00 && waited < 10) begin
                @(negedge clock);
                waited++;
            end
            chk("rr_ack", 64'(ack), (n % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_grant", 64'(grant), (n % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_rdata", 64'(read_data), (n % 2 == 0) ? 64'hDEADBEAA : 64'hCAFEF00D);
        end
        request = '0;
        repeat (2) @(negedge clock);

        // Master 1 drops request and changes its command during ACCESS.
        request = 2'b10;
        write_enable[1] = 1'b1;
        address[63:32] = 32'h30;
        write_select[7:4] = 4'hF;
        write_data[63:32] = 32'h55AA55AA;
        @(negedge clock);
        chk("drop_grant", 64'(grant), 64'd2);
        request = '0;
        address[63:32] = 32'h40;
        write_data[63:32] = 32'h0;
        @(negedge clock);
        @(negedge clock);
        chk("drop_ack", 64'(ack), 64'd2);
        seen = '0;
        repeat (4) begin
            @(negedge clock);
            seen = seen | ack;
        end
        chk("drop_ack_once", 64'(seen), 64'd0);
        txn("rd30", 1, 1'b0, 32'h30, 4'h0, 32'h0, 32'h55AA55AA, 1'b0);

        // Out-of-range write: flagged and suppressed, or aliased into word 0.
`ifdef RAM_ARBITER_RANGE_CHECK_EN
        txn("wr1000", 0, 1'b1, 32'h1000, 4'hF, 32'h11111111, 32'h0, 1'b1);
        txn("rd0", 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0BADF00D, 1'b0);
        txn("rd1000", 1, 1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1);
`else
        txn("wr1000", 0, 1'b1, 32'h1000, 4'hF, 32'h11111111, 32'h0, 1'b0);
        txn("rd0", 0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h11111111, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
